// File: rtl/bp_piton_fill_assembler.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : bp_piton_fill_assembler                                         |
// | Purpose  : Collects a header flit plus payload flits into one wide cache   |
// |            fill and hands it to the cache engine over valid/yumi.          |
// | Revision : 1.0  initial release                                            |
// +----------------------------------------------------------------------------+
module bp_piton_fill_assembler #(
  parameter int flit_width_p = 64,
  parameter int fill_width_p = 256,
  parameter int len_width_p  = 8
) (
  input  logic                    clk_i,
  input  logic                    reset_n_i,
  input  logic [flit_width_p-1:0] flit_i,
  input  logic                    flit_v_i,
  output logic                    flit_ready_o,
  output logic                    fill_v_o,
  input  logic                    fill_yumi_i,
  output logic [fill_width_p-1:0] fill_data_o,
  output logic [7:0]              fill_type_o,
  output logic [7:0]              fill_mshr_o,
  output logic [len_width_p-1:0]  fill_len_o,
  output logic                    fill_overflow_o
);

  localparam int c_cap = fill_width_p / flit_width_p;

  localparam logic [1:0] c_st_hdr  = 2'd0;
  localparam logic [1:0] c_st_data = 2'd1;
  localparam logic [1:0] c_st_send = 2'd2;

  localparam logic [len_width_p-1:0] c_one = {{(len_width_p-1){1'b0}}, 1'b1};

  logic [1:0]              r_state;
  logic [1:0]              w_state_next;
  logic [len_width_p-1:0]  r_k;
  logic [len_width_p-1:0]  r_len;
  logic [7:0]              r_type;
  logic [7:0]              r_mshr;
  logic                    r_ovf;
  logic [fill_width_p-1:0] r_data;

  logic                    w_accept;
  logic                    w_last;
  logic                    w_store;
  logic [len_width_p-1:0]  w_k_next;
  logic [len_width_p-1:0]  w_hdr_len;

  assign w_hdr_len = flit_i[8 +: len_width_p];
  assign w_accept  = flit_v_i & flit_ready_o;
  assign w_k_next  = r_k + c_one;
  assign w_last    = (w_k_next == r_len);
  // Beats beyond the fill capacity are consumed but never stored.
  assign w_store   = (int'(r_k) < c_cap);

  always_ff @(posedge clk_i) begin
    if (!reset_n_i) begin
      r_state <= c_st_hdr;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      c_st_hdr: begin
        if (w_accept) begin
          w_state_next = (w_hdr_len == '0) ? c_st_send : c_st_data;
        end
      end
      c_st_data: begin
        if (w_accept && w_last) begin
          w_state_next = c_st_send;
        end
      end
      c_st_send: begin
        if (fill_yumi_i) begin
          w_state_next = c_st_hdr;
        end
      end
      default: w_state_next = c_st_hdr;
    endcase
  end

  // Ready is gated by reset so nothing is taken while the block is held.
  always_comb begin
    flit_ready_o = reset_n_i && (r_state != c_st_send);
    fill_v_o     = (r_state == c_st_send);
  end

  always_ff @(posedge clk_i) begin
    if (!reset_n_i) begin
      r_k    <= '0;
      r_len  <= '0;
      r_type <= '0;
      r_mshr <= '0;
      r_ovf  <= 1'b0;
      r_data <= '0;
    end else if (w_accept && (r_state == c_st_hdr)) begin
      r_type <= flit_i[7:0];
      r_len  <= w_hdr_len;
      r_mshr <= flit_i[23:16];
      r_ovf  <= 1'b0;
      r_data <= '0;
      r_k    <= '0;
    end else if (w_accept && (r_state == c_st_data)) begin
      r_k <= w_k_next;
      if (w_store) begin
        for (int i = 0; i < c_cap; i++) begin
          if (int'(r_k) == i) begin
            r_data[i*flit_width_p +: flit_width_p] <= flit_i;
          end
        end
      end else begin
        r_ovf <= 1'b1;
      end
    end
  end

  assign fill_data_o     = r_data;
  assign fill_type_o     = r_type;
  assign fill_mshr_o     = r_mshr;
  assign fill_len_o      = r_len;
  assign fill_overflow_o = r_ovf;

endmodule
`default_nettype wire

// File: tb/tb_bp_piton_fill_assembler.sv
`default_nettype none
// Bench for bp_piton_fill_assembler: directed packets with a packet-level
// reference model checked every cycle, plus literal expectations per packet.
module tb_bp_piton_fill_assembler;
  localparam int FW  = 64;
  localparam int DW  = 256;
  localparam int LW  = 8;
  localparam int CAP = DW / FW;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [FW-1:0] flit;
  logic          flit_v;
  logic          flit_ready;
  logic          fill_v;
  logic          yumi;
  logic [DW-1:0] fill_data;
  logic [7:0]    fill_type;
  logic [7:0]    fill_mshr;
  logic [LW-1:0] fill_len;
  logic          fill_ovf;

  bp_piton_fill_assembler #(
    .flit_width_p(FW),
    .fill_width_p(DW),
    .len_width_p (LW)
  ) dut (
    .clk_i          (clk),
    .reset_n_i      (rst_n),
    .flit_i         (flit),
    .flit_v_i       (flit_v),
    .flit_ready_o   (flit_ready),
    .fill_v_o       (fill_v),
    .fill_yumi_i    (yumi),
    .fill_data_o    (fill_data),
    .fill_type_o    (fill_type),
    .fill_mshr_o    (fill_mshr),
    .fill_len_o     (fill_len),
    .fill_overflow_o(fill_ovf)
  );

  always #5 clk = ~clk;

  int vectors     = 0;
  int miscompares = 0;

  task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Packet-level model: gathers a header and its N beats, then publishes a fill.
  bit            m_v = 1'b0;
  bit            m_in_pkt = 1'b0;
  int            m_cnt = 0;
  logic [DW-1:0] m_buf = '0;
  logic [DW-1:0] m_data = '0;
  logic [7:0]    m_type = '0, m_mshr = '0, m_len = '0;
  bit            m_ovf = 1'b0;
  logic [7:0]    p_type, p_mshr, p_len;

  task automatic publish();
    m_v    = 1'b1;
    m_data = m_buf;
    m_type = p_type;
    m_mshr = p_mshr;
    m_len  = p_len;
    m_ovf  = (int'(p_len) > CAP);
  endtask

  always @(posedge clk) begin
    if (!rst_n) begin
      m_v = 1'b0; m_in_pkt = 1'b0; m_data = '0;
      m_type = '0; m_mshr = '0; m_len = '0; m_ovf = 1'b0;
    end else if (m_v) begin
      if (yumi) m_v = 1'b0;
    end else if (flit_v) begin
      if (!m_in_pkt) begin
        p_type = flit[7:0];
        p_len  = flit[15:8];
        p_mshr = flit[23:16];
        m_cnt  = 0;
        m_buf  = '0;
        if (p_len == 8'd0) publish();
        else m_in_pkt = 1'b1;
      end else begin
        if (m_cnt < CAP) m_buf[m_cnt*FW +: FW] = flit;
        m_cnt++;
        if (m_cnt == int'(p_len)) begin
          m_in_pkt = 1'b0;
          publish();
        end
      end
    end
  end

  always @(negedge clk) begin
    check("ready", {255'd0, flit_ready}, {255'd0, rst_n && !m_v});
    check("fill_v", {255'd0, fill_v}, {255'd0, m_v});
    if (m_v) begin
      check("m_data", fill_data, m_data);
      check("m_type", {248'd0, fill_type}, {248'd0, m_type});
      check("m_mshr", {248'd0, fill_mshr}, {248'd0, m_mshr});
      check("m_len", {248'd0, fill_len}, {248'd0, m_len});
      check("m_ovf", {255'd0, fill_ovf}, {255'd0, m_ovf});
    end
  end

  task automatic send(input logic [FW-1:0] f);
    bit acc = 1'b0;
    flit   = f;
    flit_v = 1'b1;
    for (int i = 0; i < 50 && !acc; i++) begin
      @(negedge clk);
      acc = flit_ready;
      @(posedge clk);
      #1;
    end
    if (!acc) begin
      vectors++;
      miscompares++;
      $display("FAIL send_timeout: got no ready expected ready within 50 cycles");
    end
    flit_v = 1'b0;
  endtask

  task automatic expect_fill(input string name);
    @(negedge clk);
    check(name, {255'd0, fill_v}, {255'd1});
  endtask

  task automatic take();
    @(posedge clk); #1 yumi = 1'b1;
    @(posedge clk); #1 yumi = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0; flit = '0; flit_v = 1'b0; yumi = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_ready", {255'd0, flit_ready}, '0);
    check("rst_fill_v", {255'd0, fill_v}, '0);
    check("rst_data", fill_data, '0);
    check("rst_type", {248'd0, fill_type}, '0);
    check("rst_mshr", {248'd0, fill_mshr}, '0);
    check("rst_len", {248'd0, fill_len}, '0);
    check("rst_ovf", {255'd0, fill_ovf}, '0);
    @(posedge clk); #1 rst_n = 1'b1;

    // Four beats, exact fit
    send(64'h0000_0000_0003_0405);
    send(64'h1111_1111_1111_1111);
    send(64'h2222_2222_2222_2222);
    send(64'h3333_3333_3333_3333);
    send(64'h4444_4444_4444_4444);
    expect_fill("t1_latency");
    check("t1_data", fill_data, {64'h4444_4444_4444_4444, 64'h3333_3333_3333_3333,
                                 64'h2222_2222_2222_2222, 64'h1111_1111_1111_1111});
    check("t1_type", {248'd0, fill_type}, 256'h05);
    check("t1_mshr", {248'd0, fill_mshr}, 256'h03);
    check("t1_ovf", {255'd0, fill_ovf}, '0);
    take();

    // Header-only store ack
    send(64'h0000_0000_0007_000A);
    expect_fill("t2_latency");
    check("t2_data", fill_data, '0);
    check("t2_len", {248'd0, fill_len}, '0);
    check("t2_type", {248'd0, fill_type}, 256'h0A);
    take();

    // Short packet, upper words zero
    send(64'h0000_0000_0001_0206);
    send(64'h0123_4567_89AB_CDEF);
    send(64'hFEDC_BA98_7654_3210);
    expect_fill("t3_latency");
    check("t3_data", fill_data, {128'd0, 64'hFEDC_BA98_7654_3210, 64'h0123_4567_89AB_CDEF});
    take();

    // Overflow: six beats into four slots
    send(64'h0000_0000_0005_0607);
    for (int i = 0; i < 6; i++) send({8{8'(8'hA0 + i)}});
    expect_fill("t4_latency");
    check("t4_data", fill_data, {64'hA3A3_A3A3_A3A3_A3A3, 64'hA2A2_A2A2_A2A2_A2A2,
                                 64'hA1A1_A1A1_A1A1_A1A1, 64'hA0A0_A0A0_A0A0_A0A0});
    check("t4_ovf", {255'd0, fill_ovf}, 256'd1);
    check("t4_len", {248'd0, fill_len}, 256'd6);
    take();

    // Clean packet after overflow, then a long stall on yumi
    send(64'h0000_0000_0009_0101);
    send(64'h5555_5555_5555_5555);
    expect_fill("t5_latency");
    check("t5_ovf", {255'd0, fill_ovf}, '0);
    check("t5_data", fill_data, {192'd0, 64'h5555_5555_5555_5555});
    flit = 64'h0000_0000_000C_000B;
    flit_v = 1'b1;
    repeat (10) @(negedge clk);
    check("t5_stall_ready", {255'd0, flit_ready}, '0);
    @(posedge clk); #1 yumi = 1'b1;
    @(posedge clk); #1 yumi = 1'b0;
    @(negedge clk);
    check("t5_ready_after_yumi", {255'd0, flit_ready}, 256'd1);
    @(posedge clk); #1 flit_v = 1'b0;
    @(negedge clk);
    check("t5_hdr_fill_v", {255'd0, fill_v}, 256'd1);
    check("t5_hdr_type", {248'd0, fill_type}, 256'h0B);
    take();

    // Reset mid-packet, then a fresh one-beat packet
    send(64'h0000_0000_0002_0403);
    send(64'hBAD0_BAD0_BAD0_BAD0);
    send(64'hBAD1_BAD1_BAD1_BAD1);
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("t6_rst_fill_v", {255'd0, fill_v}, '0);
    check("t6_rst_data", fill_data, '0);
    @(posedge clk); #1 rst_n = 1'b1;
    send(64'h0000_0000_0004_010C);
    send(64'hDEAD_BEEF_CAFE_F00D);
    expect_fill("t6_latency");
    check("t6_data", fill_data, {192'd0, 64'hDEAD_BEEF_CAFE_F00D});
    check("t6_mshr", {248'd0, fill_mshr}, 256'h04);
    take();
    repeat (3) @(posedge clk);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
`default_nettype wire
